dbf_line_seq: RTL and testbench



---
 rtl/dbf_line_seq_pkg.sv | 28 ++
 rtl/dbf_seq_phase_cnt.sv | 33 +++
 rtl/dbf_line_seq.sv | 170 +++++++++++++++++
 tb/tb_dbf_line_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dbf_line_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dbf_line_seq_pkg
// Description : State encoding and bus-width defaults shared by the DBF
//               line sequencer and the dbf_chN channel bank.
// Revision    : 1.0 - initial release
// ============================================================================
package dbf_line_seq_pkg;

    localparam int ADDR_WD_DEF = 10;
    localparam int LCNT_WD_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TX   = 3'd1,
        ST_DEAD = 3'd2,
        ST_RX   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dbf_seq_phase_cnt.sv
`default_nettype none
// ============================================================================
// Module      : dbf_seq_phase_cnt
// Description : Loadable down-counter; tc is high while the count is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module dbf_seq_phase_cnt #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             tc
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign tc = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/dbf_line_seq.sv
`default_nettype none
// ============================================================================
// Module      : dbf_line_seq
// Description : Per-scanline TX / dead-time / RX sequencer for the DBF bank.
//               Optional multi-line frames under macro DBF_SEQ_FRAME_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dbf_line_seq
    import dbf_line_seq_pkg::*;
#(
    parameter int ADDR_WD  = ADDR_WD_DEF,
    parameter int TX_CYC   = 64,
    parameter int DEAD_CYC = 16,
    parameter int LCNT_WD  = LCNT_WD_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               line_req,
    input  logic               abort,
    input  logic [ADDR_WD-1:0] rx_len,
`ifdef DBF_SEQ_FRAME_EN
    input  logic [LCNT_WD-1:0] frame_lines,
    output logic               frame_done,
`endif
    output logic               busy,
    output logic               tx_en,
    output logic               start,
    output logic [ADDR_WD-1:0] dbf_lut_addr,
    output logic               dbf_lut_we,
    output logic               line_done,
    output logic [LCNT_WD-1:0] line_cnt
);

    localparam int CNT_WD = max3(ADDR_WD, $clog2(TX_CYC + 1), $clog2(DEAD_CYC + 1));
    localparam logic [CNT_WD-1:0] TX_LOAD   = CNT_WD'(TX_CYC - 1);
    localparam logic [CNT_WD-1:0] DEAD_LOAD = CNT_WD'(DEAD_CYC - 1);

    state_t              r_state;
    state_t              w_state_n;
    logic [ADDR_WD-1:0]  r_len_q;
    logic [ADDR_WD-1:0]  w_len_n;
    logic                w_cnt_load;
    logic [CNT_WD-1:0]   w_cnt_val;
    logic                w_cnt_dec;
    logic                w_tc;
`ifdef DBF_SEQ_FRAME_EN
    logic [LCNT_WD-1:0]  r_left;
    logic [LCNT_WD-1:0]  w_left_n;
`endif

    dbf_seq_phase_cnt #(
        .WIDTH    (CNT_WD)
    ) u_phase_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_cnt_load),
        .load_val (w_cnt_val),
        .dec      (w_cnt_dec),
        .tc       (w_tc)
    );

    always_comb begin
        w_state_n  = r_state;
        w_len_n    = r_len_q;
        w_cnt_load = 1'b0;
        w_cnt_val  = '0;
        w_cnt_dec  = 1'b0;
`ifdef DBF_SEQ_FRAME_EN
        w_left_n   = r_left;
`endif
        case (r_state)
            ST_IDLE: begin
                if (line_req && !abort) begin
                    w_state_n  = ST_TX;
                    w_len_n    = rx_len;
                    w_cnt_load = 1'b1;
                    w_cnt_val  = TX_LOAD;
`ifdef DBF_SEQ_FRAME_EN
                    w_left_n   = (frame_lines == '0) ? LCNT_WD'(1) : frame_lines;
`endif
                end
            end
            ST_TX: begin
                if (w_tc) begin
                    w_state_n  = ST_DEAD;
                    w_cnt_load = 1'b1;
                    w_cnt_val  = DEAD_LOAD;
                end else begin
                    w_cnt_dec  = 1'b1;
                end
            end
            ST_DEAD: begin
                if (w_tc) begin
                    if (r_len_q == '0) begin
                        w_state_n  = ST_DONE;
                    end else begin
                        w_state_n  = ST_RX;
                        w_cnt_load = 1'b1;
                        w_cnt_val  = CNT_WD'(r_len_q) - CNT_WD'(1);
                    end
                end else begin
                    w_cnt_dec  = 1'b1;
                end
            end
            ST_RX: begin
                if (w_tc) begin
                    w_state_n = ST_DONE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_n = ST_IDLE;
`ifdef DBF_SEQ_FRAME_EN
                // Frame continues straight into the next transmit window.
                if (r_left > LCNT_WD'(1)) begin
                    w_state_n  = ST_TX;
                    w_left_n   = r_left - 1'b1;
                    w_cnt_load = 1'b1;
                    w_cnt_val  = TX_LOAD;
                end
`endif
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
        if (abort && (r_state != ST_IDLE)) begin
            w_state_n = ST_IDLE;
        end
    end

    // Outputs decode the next state so they move on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_len_q      <= '0;
            busy         <= 1'b0;
            tx_en        <= 1'b0;
            start        <= 1'b0;
            dbf_lut_addr <= '0;
            dbf_lut_we   <= 1'b0;
            line_done    <= 1'b0;
            line_cnt     <= '0;
`ifdef DBF_SEQ_FRAME_EN
            r_left       <= '0;
            frame_done   <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_n;
            r_len_q      <= w_len_n;
            busy         <= (w_state_n != ST_IDLE);
            tx_en        <= (w_state_n == ST_TX);
            start        <= (w_state_n == ST_RX);
            dbf_lut_we   <= (w_state_n == ST_RX);
            line_done    <= (w_state_n == ST_DONE);
            dbf_lut_addr <= ((w_state_n == ST_RX) && (r_state == ST_RX)) ?
                            dbf_lut_addr + 1'b1 : '0;
            if (w_state_n == ST_DONE) begin
                line_cnt <= line_cnt + 1'b1;
            end
`ifdef DBF_SEQ_FRAME_EN
            r_left       <= w_left_n;
            frame_done   <= (w_state_n == ST_DONE) && (r_left == LCNT_WD'(1));
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dbf_line_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_dbf_line_seq
// Description : Directed self-checking bench for dbf_line_seq (TX=4, DEAD=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dbf_line_seq;

    localparam int ADDR_WD = 10;
    localparam int LCNT_WD = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               line_req;
    logic               abort;
    logic [ADDR_WD-1:0] rx_len;
    logic               busy;
    logic               tx_en;
    logic               start;
    logic [ADDR_WD-1:0] dbf_lut_addr;
    logic               dbf_lut_we;
    logic               line_done;
    logic [LCNT_WD-1:0] line_cnt;
`ifdef DBF_SEQ_FRAME_EN
    logic [LCNT_WD-1:0] frame_lines;
    logic               frame_done;
`endif

    int checks = 0;
    int errors = 0;

    dbf_line_seq #(
        .ADDR_WD      (ADDR_WD),
        .TX_CYC       (4),
        .DEAD_CYC     (2),
        .LCNT_WD      (LCNT_WD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .line_req     (line_req),
        .abort        (abort),
        .rx_len       (rx_len),
`ifdef DBF_SEQ_FRAME_EN
        .frame_lines  (frame_lines),
        .frame_done   (frame_done),
`endif
        .busy         (busy),
        .tx_en        (tx_en),
        .start        (start),
        .dbf_lut_addr (dbf_lut_addr),
        .dbf_lut_we   (dbf_lut_we),
        .line_done    (line_done),
        .line_cnt     (line_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input int exp_cnt);
        chk({tag, ".busy"},  32'(busy), 0);
        chk({tag, ".tx_en"}, 32'(tx_en), 0);
        chk({tag, ".start"}, 32'(start), 0);
        chk({tag, ".addr"},  32'(dbf_lut_addr), 0);
        chk({tag, ".we"},    32'(dbf_lut_we), 0);
        chk({tag, ".done"},  32'(line_done), 0);
        chk({tag, ".cnt"},   32'(line_cnt), 32'(exp_cnt));
    endtask

    initial begin
        rst_n    = 1'b0;
        line_req = 1'b0;
        abort    = 1'b0;
        rx_len   = '0;
`ifdef DBF_SEQ_FRAME_EN
        frame_lines = 8'd1;
`endif
        step();
        step();
        chk_idle("reset", 0);
        rst_n = 1'b1;
        step();

        // Normal line, rx_len=5
        rx_len = 10'd5; line_req = 1'b1;
        step();
        line_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("l1.tx_en", 32'(tx_en), 1);
            chk("l1.tx_start", 32'(start), 0);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            chk("l1.dead_tx", 32'(tx_en), 0);
            chk("l1.dead_start", 32'(start), 0);
            chk("l1.dead_busy", 32'(busy), 1);
            step();
        end
        for (int i = 0; i < 5; i++) begin
            chk("l1.rx_start", 32'(start), 1);
            chk("l1.rx_we", 32'(dbf_lut_we), 1);
            chk("l1.rx_addr", 32'(dbf_lut_addr), 32'(i));
            step();
        end
        chk("l1.done", 32'(line_done), 1);
        chk("l1.done_start", 32'(start), 0);
        chk("l1.done_addr", 32'(dbf_lut_addr), 0);
        chk("l1.cnt", 32'(line_cnt), 1);
        step();
        chk("l1.idle_busy", 32'(busy), 0);
        chk("l1.idle_done", 32'(line_done), 0);

        // Zero-length receive
        rx_len = 10'd0; line_req = 1'b1;
        step();
        line_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("l0.no_start", 32'(start), 0);
            chk("l0.tx_phase", 32'(tx_en), (i < 4) ? 1 : 0);
            step();
        end
        chk("l0.done", 32'(line_done), 1);
        chk("l0.cnt", 32'(line_cnt), 2);
        step();
        chk("l0.idle", 32'(busy), 0);

        // Abort in RX at addr=1
        rx_len = 10'd5; line_req = 1'b1;
        step();
        line_req = 1'b0;
        repeat (6) step();
        chk("ab.addr0", 32'(dbf_lut_addr), 0);
        step();
        chk("ab.addr1", 32'(dbf_lut_addr), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_idle("ab.clear", 2);
        step();
        chk("ab.no_done", 32'(line_done), 0);

        // Abort and line_req together in IDLE
        abort = 1'b1; line_req = 1'b1;
        step();
        abort = 1'b0; line_req = 1'b0;
        chk("abreq.busy", 32'(busy), 0);
        chk("abreq.tx", 32'(tx_en), 0);

        // line_req during TX ignored, rx_len change ignored
        rx_len = 10'd5; line_req = 1'b1;
        step();
        line_req = 1'b0;
        step();
        line_req = 1'b1; rx_len = 10'd9;
        step();
        line_req = 1'b0;
        repeat (4) step();
        for (int i = 0; i < 5; i++) begin
            chk("rq.rx_start", 32'(start), 1);
            chk("rq.rx_addr", 32'(dbf_lut_addr), 32'(i));
            step();
        end
        chk("rq.done", 32'(line_done), 1);
        chk("rq.done_start", 32'(start), 0);
        chk("rq.cnt", 32'(line_cnt), 3);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rq.not_queued", 32'(busy), 0);
        end

        // Reset mid-TX, then a fresh line
        rx_len = 10'd2; line_req = 1'b1;
        step();
        line_req = 1'b0;
        step();
        chk("rs.tx", 32'(tx_en), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_idle("rs.clear", 0);
        line_req = 1'b1;
        step();
        line_req = 1'b0;
        chk("rs.tx_again", 32'(tx_en), 1);
        repeat (6) step();
        chk("rs.start", 32'(start), 1);
        chk("rs.addr0", 32'(dbf_lut_addr), 0);
        step();
        chk("rs.addr1", 32'(dbf_lut_addr), 1);
        step();
        chk("rs.done", 32'(line_done), 1);
        chk("rs.cnt", 32'(line_cnt), 1);
        step();

`ifdef DBF_SEQ_FRAME_EN
        // Bring line_cnt to 255 with single-line frames, then a 3-line frame
        rx_len = 10'd0; frame_lines = 8'd1;
        for (int n = 0; n < 254; n++) begin
            line_req = 1'b1;
            step();
            line_req = 1'b0;
            for (int t = 0; t < 20 && busy; t++) step();
            if (busy) chk("fr.pre_timeout", 32'(busy), 0);
        end
        chk("fr.pre_cnt", 32'(line_cnt), 255);
        rx_len = 10'd1; frame_lines = 8'd3; line_req = 1'b1;
        step();
        line_req = 1'b0;
        for (int j = 0; j < 3; j++) begin
            repeat (7) step();
            chk("fr.line_done", 32'(line_done), 1);
            chk("fr.frame_done", 32'(frame_done), (j == 2) ? 1 : 0);
            chk("fr.cnt", 32'(line_cnt), 32'(j));
            step();
            chk("fr.frame_pulse", 32'(frame_done), 0);
            if (j < 2) chk("fr.no_gap", 32'(tx_en), 1);
            else       chk("fr.end_idle", 32'(busy), 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
